// File: rtl/sym_aligner.sv
// Serial-to-10b word aligner: hunts for K28.x commas, verifies the phase, then emits aligned symbols.
// Outputs registered one cycle after the bit_valid cycle carrying bit j; no backpressure (bit_valid gaps only stall).
module sym_aligner #(
  parameter int LOCK_COMMAS  = 3,
  parameter int MISALIGN_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [9:0] sym_out,
  output logic       sym_valid,
  output logic       sym_is_comma,
  output logic       locked,
  output logic       realign
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [2:0] LOCK_N = 3'(LOCK_COMMAS);
  localparam logic [2:0] MIS_N  = 3'(MISALIGN_MAX);

  state_t     state;
  logic [9:1] sr;  // oldest bit of the window is never needed again, so it is not stored
  logic [9:0] win;
  logic [3:0] bit_cnt;
  logic [2:0] comma_cnt;
  logic [2:0] mis_cnt;
  logic       comma;
  logic       boundary;

  assign win      = {bit_in, sr};
  assign comma    = (win[6:0] == 7'b1111100) || (win[6:0] == 7'b0000011);
  assign boundary = (bit_cnt == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HUNT;
      sr           <= '0;
      bit_cnt      <= '0;
      comma_cnt    <= '0;
      mis_cnt      <= '0;
      sym_out      <= '0;
      sym_valid    <= 1'b0;
      sym_is_comma <= 1'b0;
      locked       <= 1'b0;
      realign      <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      realign   <= 1'b0;
      if (bit_valid) begin
        sr      <= win[9:1];
        bit_cnt <= boundary ? 4'd0 : bit_cnt + 4'd1;
        case (state)
          HUNT: begin
            if (comma) begin
              bit_cnt   <= 4'd0;
              comma_cnt <= 3'd1;
              if (LOCK_N == 3'd1) begin
                state        <= LOCKED;
                locked       <= 1'b1;
                sym_valid    <= 1'b1;
                sym_out      <= win;
                sym_is_comma <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (boundary) begin
              if (comma) begin
                comma_cnt <= comma_cnt + 3'd1;
                // The locking comma itself is the first symbol handed downstream.
                if (comma_cnt + 3'd1 == LOCK_N) begin
                  state        <= LOCKED;
                  locked       <= 1'b1;
                  sym_valid    <= 1'b1;
                  sym_out      <= win;
                  sym_is_comma <= 1'b1;
                end
              end
            end else if (comma) begin
              bit_cnt   <= 4'd0;
              comma_cnt <= 3'd1;
            end
          end
          LOCKED: begin
            if (boundary) begin
              sym_valid    <= 1'b1;
              sym_out      <= win;
              sym_is_comma <= comma;
              if (comma) mis_cnt <= 3'd0;
            end else if (comma) begin
              // Misplaced commas are tolerated until enough arrive in a row.
              if (mis_cnt + 3'd1 == MIS_N) begin
                state     <= HUNT;
                locked    <= 1'b0;
                realign   <= 1'b1;
                comma_cnt <= 3'd0;
                mis_cnt   <= 3'd0;
              end else begin
                mis_cnt <= mis_cnt + 3'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sym_aligner.sv
// Directed bench for sym_aligner with a scoreboard of expected symbols.
module tb_sym_aligner;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic [9:0] sym_out;
  logic       sym_valid;
  logic       sym_is_comma;
  logic       locked;
  logic       realign;

  sym_aligner #(.LOCK_COMMAS(3), .MISALIGN_MAX(2)) dut (
    .clk(clk),
    .rst(rst),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .sym_out(sym_out),
    .sym_valid(sym_valid),
    .sym_is_comma(sym_is_comma),
    .locked(locked),
    .realign(realign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] sym;
    logic       comma;
  } exp_t;

  localparam logic [9:0] K_NEG  = 10'h17C;  // K28.5 RD-
  localparam logic [9:0] K_POS  = 10'h283;  // K28.5 RD+
  localparam logic [9:0] D21_5  = 10'h155;
  localparam logic [9:0] SPUR   = 10'h0F9;  // data word hiding a comma at an off-boundary offset
  localparam logic [9:0] SLIP_W = 10'h2F8;  // window seen at the stale boundary after a one-bit slip

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic exp_locked = 1'b0;
  bit   gap_en = 1'b0;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    bit_in    = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    chk("gap_sym_valid", {9'd0, sym_valid}, 10'd0);
    chk("gap_realign", {9'd0, realign}, 10'd0);
    chk("gap_locked", {9'd0, locked}, {9'd0, exp_locked});
  endtask

  task automatic send_bit(input logic b, input bit emit, input exp_t e,
                          input logic lock_after, input logic rea);
    exp_t got;
    if (gap_en) repeat ($urandom_range(0, 2)) idle();
    if (emit) sb.push_back(e);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk);
    #1;
    exp_locked = lock_after;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("sym_valid", {9'd0, sym_valid}, 10'd1);
      chk("sym_out", sym_out, got.sym);
      chk("sym_is_comma", {9'd0, sym_is_comma}, {9'd0, got.comma});
    end else begin
      chk("no_strobe", {9'd0, sym_valid}, 10'd0);
    end
    chk("locked", {9'd0, locked}, {9'd0, exp_locked});
    chk("realign", {9'd0, realign}, {9'd0, rea});
    bit_valid = 1'b0;
  endtask

  task automatic send_sym(input logic [9:0] s, input int emit_idx, input logic [9:0] esym,
                          input logic ecomma, input logic lock_after, input logic rea_at_j);
    exp_t e;
    e.sym   = esym;
    e.comma = ecomma;
    for (int i = 0; i < 10; i++)
      send_bit(s[i], i == emit_idx, e, (i == 9) ? lock_after : exp_locked,
               (i == 9) ? rea_at_j : 1'b0);
  endtask

  task automatic sym_emit(input logic [9:0] s, input logic c);
    send_sym(s, 9, s, c, 1'b1, 1'b0);
  endtask

  task automatic sym_quiet(input logic [9:0] s);
    send_sym(s, -1, 10'd0, 1'b0, exp_locked, 1'b0);
  endtask

  initial begin
    exp_t none;
    none      = '0;
    rst       = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;

    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("rst_sym_valid", {9'd0, sym_valid}, 10'd0);
      chk("rst_sym_out", sym_out, 10'd0);
      chk("rst_sym_is_comma", {9'd0, sym_is_comma}, 10'd0);
      chk("rst_locked", {9'd0, locked}, 10'd0);
      chk("rst_realign", {9'd0, realign}, 10'd0);
    end
    @(negedge clk);
    rst       = 1'b0;
    bit_valid = 1'b0;

    // Lock acquisition after a random preamble
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, none, 1'b0, 1'b0);
    sym_quiet(K_NEG);
    sym_quiet(K_NEG);
    sym_emit(K_NEG, 1'b1);
    sym_emit(D21_5, 1'b0);

    // Both polarities with bit_valid gaps
    gap_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sym_emit(K_NEG, 1'b1);
      sym_emit(K_POS, 1'b1);
    end
    gap_en = 1'b0;

    // One-bit slip: two misaligned commas drop lock, three more relock
    send_bit(1'b0, 1'b0, none, 1'b1, 1'b0);
    send_sym(K_NEG, 8, SLIP_W, 1'b0, 1'b1, 1'b0);
    send_sym(K_NEG, 8, SLIP_W, 1'b0, 1'b0, 1'b1);
    sym_quiet(K_NEG);
    sym_quiet(K_NEG);
    sym_emit(K_NEG, 1'b1);

    // Isolated misaligned commas are absorbed
    sym_emit(SPUR, 1'b0);
    sym_emit(K_NEG, 1'b1);
    sym_emit(SPUR, 1'b0);
    sym_emit(K_NEG, 1'b1);
    sym_emit(D21_5, 1'b0);

    // Asynchronous reset between edges while locked
    sym_emit(K_NEG, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", {9'd0, locked}, 10'd0);
    chk("arst_sym_valid", {9'd0, sym_valid}, 10'd0);
    chk("arst_sym_out", sym_out, 10'd0);
    chk("arst_realign", {9'd0, realign}, 10'd0);
    exp_locked = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_hold_locked", {9'd0, locked}, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    sym_quiet(K_NEG);
    sym_quiet(K_NEG);
    sym_emit(K_NEG, 1'b1);
    sym_emit(D21_5, 1'b0);

    chk("scoreboard_empty", 10'(sb.size()), 10'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
